// File: rtl/if_id_buf.sv
// Two-entry elastic buffer between instruction fetch and decode.
// Holds the output entry plus one skid entry so synchronous imem data survives decode stalls.
module if_id_buf #(
   parameter int              XLEN  = 32,
   parameter logic [XLEN-1:0] NOP   = 32'h00000013,
   parameter int              CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_pc,
   input  logic [XLEN-1:0]  if_inst,
   output logic             if_ready,
   input  logic             stall,
   input  logic             flush,
   output logic             id_valid,
   output logic [XLEN-1:0]  id_pc,
   output logic [XLEN-1:0]  id_inst,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [XLEN-1:0]   out_pc_reg, out_inst_reg;
   logic [XLEN-1:0]   skid_pc_reg, skid_inst_reg;
   logic [CNT_W-1:0]  bubble_cnt_reg;

   logic accept, advance;
   logic load_out, out_from_skid, load_skid;

   assign if_ready = ~rst & (state_reg != S_FULL);
   assign id_valid = (state_reg != S_EMPTY);
   assign accept   = if_valid & if_ready;
   assign advance  = id_valid & ~stall;

   always_comb begin
      state_next    = state_reg;
      load_out      = 1'b0;
      out_from_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         // Squash everything, including a pair accepted this very cycle.
         state_next = S_EMPTY;
      end else begin
         case (state_reg)
            S_EMPTY: begin
               if (accept) begin
                  state_next = S_ONE;
                  load_out   = 1'b1;
               end
            end
            S_ONE: begin
               if (advance && accept) begin
                  load_out = 1'b1;
               end else if (advance) begin
                  state_next = S_EMPTY;
               end else if (accept) begin
                  state_next = S_FULL;
                  load_skid  = 1'b1;
               end
            end
            S_FULL: begin
               if (advance) begin
                  state_next    = S_ONE;
                  load_out      = 1'b1;
                  out_from_skid = 1'b1;
               end
            end
            default: state_next = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_EMPTY;
         out_pc_reg    <= '0;
         out_inst_reg  <= NOP;
         skid_pc_reg   <= '0;
         skid_inst_reg <= NOP;
      end else begin
         state_reg <= state_next;
         if (load_out) begin
            out_pc_reg   <= out_from_skid ? skid_pc_reg   : if_pc;
            out_inst_reg <= out_from_skid ? skid_inst_reg : if_inst;
         end
         if (load_skid) begin
            skid_pc_reg   <= if_pc;
            skid_inst_reg <= if_inst;
         end
      end
   end

   // Counts bubble cycles seen by decode; saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_reg <= '0;
      end else if (!id_valid && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
         bubble_cnt_reg <= bubble_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign id_pc      = id_valid ? out_pc_reg   : '0;
   assign id_inst    = id_valid ? out_inst_reg : NOP;
   assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed scenario tasks plus a scoreboard that
// tracks accepted pairs and checks them as decode consumes them.
module tb_if_id_buf;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [XLEN-1:0] NOP = 32'h00000013;

   logic             clk = 1'b0;
   logic             rst, if_valid, stall, flush;
   logic [XLEN-1:0]  if_pc, if_inst;
   logic             if_ready, id_valid;
   logic [XLEN-1:0]  id_pc, id_inst;
   logic [CNT_W-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;
   logic [2*XLEN-1:0] exp_q[$];

   if_id_buf #(.XLEN(XLEN), .NOP(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_ready(if_ready), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_inst(id_inst), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop on each decode advance, push on each accepted input.
   always @(negedge clk) begin
      if (!done) begin
         if (rst) begin
            exp_q.delete();
         end else begin
            if (!id_valid) begin
               checks++;
               if (id_inst !== NOP || id_pc !== '0) begin
                  errors++;
                  $display("FAIL bubble_out: got pc=%h inst=%h, want pc=0 inst=%h", id_pc, id_inst, NOP);
               end
            end
            if (id_valid && !stall && !flush) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: got pc=%h inst=%h, want no output", id_pc, id_inst);
               end else begin
                  logic [2*XLEN-1:0] e;
                  e = exp_q.pop_front();
                  if ({id_pc, id_inst} !== e) begin
                     errors++;
                     $display("FAIL sb_order: got pc=%h inst=%h, want pc=%h inst=%h",
                              id_pc, id_inst, e[2*XLEN-1:XLEN], e[XLEN-1:0]);
                  end else begin
                     $display("sb: pc=%h inst=%h ok", id_pc, id_inst);
                  end
               end
            end
            if (flush) exp_q.delete();
            else if (if_valid && if_ready) exp_q.push_back({if_pc, if_inst});
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; if_valid = 1'b1; if_pc = 32'h44; if_inst = 32'h1234; stall = 1'b0; flush = 1'b0;
      repeat (3) tick();
      checks++;
      if (if_ready !== 1'b0 || id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0 || bubble_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b pc=%h inst=%h cnt=%0d, want 0 0 0 %h 0",
                  if_ready, id_valid, id_pc, id_inst, bubble_cnt, NOP);
      end
      rst = 1'b0; if_valid = 1'b0;
      #1;
      checks++;
      if (if_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, want 1", if_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_bubble_cnt();
      repeat (5) tick();
      checks++;
      if (bubble_cnt !== 4'd5) begin
         errors++;
         $display("FAIL bubble_cnt_5: got %0d, want 5", bubble_cnt);
      end
      repeat (15) tick();
      checks++;
      if (bubble_cnt !== 4'd15) begin
         errors++;
         $display("FAIL bubble_cnt_sat: got %0d, want 15", bubble_cnt);
      end
      tick();
      checks++;
      if (bubble_cnt !== 4'd15) begin
         errors++;
         $display("FAIL bubble_cnt_nowrap: got %0d, want 15", bubble_cnt);
      end
      $display("test_bubble_cnt done");
   endtask

   task automatic test_stream();
      logic [XLEN-1:0] pcs[3];
      logic [XLEN-1:0] ins[3];
      pcs = '{32'h0, 32'h4, 32'h8};
      ins = '{32'hA, 32'hB, 32'hC};
      for (int i = 0; i < 3; i++) begin
         if_valid = 1'b1; if_pc = pcs[i]; if_inst = ins[i];
         tick();
         checks++;
         if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_inst !== ins[i]) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b pc=%h inst=%h, want 1 %h %h", i, id_valid, id_pc, id_inst, pcs[i], ins[i]);
         end
      end
      if_valid = 1'b0;
      tick();
      checks++;
      if (id_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b, want 0", id_valid);
      end
      $display("test_stream done");
   endtask

   task automatic test_stall_skid();
      if_valid = 1'b1; if_pc = 32'h10; if_inst = 32'h110;
      tick();
      stall = 1'b1; if_pc = 32'h14; if_inst = 32'h114;
      tick();
      checks++;
      if (if_ready !== 1'b0 || id_pc !== 32'h10) begin
         errors++;
         $display("FAIL stall_full: got rdy=%b pc=%h, want 0 00000010", if_ready, id_pc);
      end
      if_pc = 32'h18; if_inst = 32'h118;
      repeat (2) tick();
      checks++;
      if (if_ready !== 1'b0 || id_pc !== 32'h10 || id_inst !== 32'h110) begin
         errors++;
         $display("FAIL stall_hold: got rdy=%b pc=%h inst=%h, want 0 00000010 00000110", if_ready, id_pc, id_inst);
      end
      stall = 1'b0;
      tick();
      checks++;
      if (id_pc !== 32'h14 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_skid_out: got pc=%h rdy=%b, want 00000014 1", id_pc, if_ready);
      end
      tick();
      checks++;
      if (id_pc !== 32'h18 || id_inst !== 32'h118) begin
         errors++;
         $display("FAIL stall_third: got pc=%h inst=%h, want 00000018 00000118", id_pc, id_inst);
      end
      if_valid = 1'b0;
      tick();
      $display("test_stall_skid done");
   endtask

   task automatic test_flush_full();
      if_valid = 1'b1; if_pc = 32'h20; if_inst = 32'h120;
      tick();
      stall = 1'b1; if_pc = 32'h24; if_inst = 32'h124;
      tick();
      flush = 1'b1; if_pc = 32'h28; if_inst = 32'h128;
      tick();
      checks++;
      if (id_valid !== 1'b0 || id_inst !== NOP || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: got v=%b inst=%h rdy=%b, want 0 %h 1", id_valid, id_inst, if_ready, NOP);
      end
      flush = 1'b0; stall = 1'b0; if_pc = 32'h100; if_inst = 32'h200;
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h200) begin
         errors++;
         $display("FAIL flush_refetch: got v=%b pc=%h inst=%h, want 1 00000100 00000200", id_valid, id_pc, id_inst);
      end
      if_valid = 1'b0;
      tick();
      $display("test_flush_full done");
   endtask

   task automatic test_flush_stall();
      if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h300;
      tick();
      stall = 1'b1; flush = 1'b1; if_pc = 32'h204; if_inst = 32'h304;
      tick();
      checks++;
      if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_stall: got v=%b rdy=%b, want 0 1", id_valid, if_ready);
      end
      stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
      tick();
      $display("test_flush_stall done");
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] next_pc = 32'h1000;
      bit acc = 1'b1;
      int budget;
      for (int i = 0; i < 300; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 19) == 0);
         // Fetch keeps a refused pair stable unless redirected by a flush.
         if (!if_valid || acc || flush) begin
            if_valid = ($urandom_range(0, 4) != 0);
            if_pc    = next_pc;
            if_inst  = $urandom;
            next_pc  = next_pc + 32'h4;
         end
         acc = if_valid && if_ready;
         tick();
      end
      stall = 1'b0; flush = 1'b0; if_valid = 1'b0;
      budget = 10;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      tick();
      checks++;
      if (exp_q.size() != 0 || id_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending v=%b, want 0 pending v=0", exp_q.size(), id_valid);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_mid_reset();
      if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h400;
      tick();
      stall = 1'b1; if_pc = 32'h304;
      tick();
      rst = 1'b1; if_pc = 32'h308;
      tick();
      checks++;
      if (id_valid !== 1'b0 || if_ready !== 1'b0 || bubble_cnt !== '0 || id_pc !== '0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b rdy=%b cnt=%0d pc=%h, want 0 0 0 0", id_valid, if_ready, bubble_cnt, id_pc);
      end
      rst = 1'b0; if_valid = 1'b0; stall = 1'b0;
      tick();
      checks++;
      if (id_valid !== 1'b0 || bubble_cnt !== 4'd1) begin
         errors++;
         $display("FAIL mid_reset_after: got v=%b cnt=%0d, want 0 1", id_valid, bubble_cnt);
      end
      $display("test_mid_reset done");
   endtask

   initial begin
      test_reset();
      test_bubble_cnt();
      test_stream();
      test_stall_skid();
      test_flush_full();
      test_flush_stall();
      test_back_to_back();
      test_mid_reset();
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
